bit_deserializer_32: RTL and testbench
======================================

Name: bit_deserializer_32

Overview:
- Inverse of the 32:1 bit-select mux path: accepts a serial bit stream and writes each bit into a 32-bit word at a counter-driven index.
- Uses a one-hot index decoder and a per-bit write enable.
- Hands completed words downstream through a valid/ready output register.
- Sits between serial peripheral inputs (feeder sensor / UART-style bit sources) and the CPU's memory-mapped input registers.

Parameters:
- WIDTH, 32, word width in bits. Only 32 is supported.
- IDX_W, 5, index counter width; must satisfy 2^IDX_W == WIDTH.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of the partially assembled word.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  deserializer can accept a bit this cycle.
- word_out  output  32  last completed word. Bit 0 is the first bit received (LSB first).
- out_valid  output  1  word_out holds an unconsumed word.
- out_ready  input  1  downstream consumes word_out this cycle.
- index  output  5  next bit position to be written (0..31).

Behaviour:
- Reset (already decided): one clock `clock`; reset `reset` is synchronous and active-high. On reset, index=0, assembly register=0, word_out=0, out_valid=0.
- Accept rule: a bit is accepted when bit_valid && bit_ready && !clear.
- bit_ready is combinational: `!clear && !(index==31 && out_valid && !out_ready)`.
  - The stall occurs only when the final bit would complete a word while the output register is still occupied.
- On accept with index<31:
  - Decoder asserts one-hot enable[index]; assembly[index] <= bit_in.
  - index <= index+1.
  - All other assembly bits hold.
- On accept with index==31:
  - word_out <= {bit_in, assembly[30:0]}; out_valid <= 1.
  - index <= 0; assembly <= 0.
- Latency: word_out and out_valid are visible the cycle after the 32nd bit's accept edge.
- Output handshake:
  - out_valid falls when out_valid && out_ready, unless a new word completes in the same cycle. In that case out_valid stays 1 and word_out takes the new word (pass-through, no bubble).
  - word_out holds its value while out_valid=0; it is not cleared on consume.
- clear:
  - Sets index <= 0 and assembly <= 0.
  - Has priority over bit acceptance in the same cycle; that bit is dropped and bit_ready=0.
  - Does not affect word_out or out_valid.
- Wrap-around: index rolls 31->0 only through word completion, never otherwise.
- No bit is ever lost while bit_ready=1. Upstream must hold bit_in and bit_valid while bit_ready=0.
- reset mid-word or with out_valid=1: the partial word and any pending output are discarded.
- Simultaneous reset and clear: reset wins; the result is identical anyway.

Decomposition:
- Shared package:
  - DESER_WIDTH=32 and DESER_IDX_W=5.
  - LAST_IDX=5'd31 constant, used by this block and by the existing mux-based serializer path.
- One sub-module: one_bit_decoder_32, a 5-to-32 one-hot decoder with enable. Build it as four 3-to-8 decoders gated by a 2-to-4 decoder on select[4:3], mirroring the mux tree's 8/8/8/8 split.
- Assembly register, index counter and output register stay in bit_deserializer_32.

Test Plan:
- Reset, then idle: index=0, out_valid=0, word_out=0, bit_ready=1 on every cycle.
- Stream 0xA5A50F3C LSB first with bit_valid continuously high and out_ready=1: out_valid=1 for exactly one cycle, one cycle after the 32nd bit's accept edge, with word_out=0xA5A50F3C; index returns to 0.
- Back-to-back words 0x00000001 then 0x80000000 with out_ready=0 until the second word's bit 31:
  - bit_ready=0 at index=31 while the first word is unconsumed.
  - Raise out_ready: first word consumed; the second word completes the same cycle; out_valid stays 1 with word_out=0x80000000.
- Feed 10 bits of 0x3FF, assert clear with bit_valid=1, then feed 32 bits of 0x12345678:
  - The bit in the clear cycle is dropped.
  - index=0 after clear.
  - Resulting word_out=0x12345678, not corrupted by the earlier partial bits.
- Gaps in bit_valid (random 0–3 idle cycles between bits) for word 0xDEADBEEF: word_out=0xDEADBEEF; index advances only on accepted bits.
- Assert reset at index=17 with out_valid=1: the next cycle shows index=0, out_valid=0, word_out=0; a subsequent full word assembles correctly from bit 0.

Source files
------------

// File: rtl/bit_deserializer_32_pkg.sv
// bit_deserializer_32_pkg: shared width, index width and last-index constants
// for the serial deserializer and the mux-based serializer path.
package bit_deserializer_32_pkg;
    localparam int DESER_WIDTH = 32;
    localparam int DESER_IDX_W = 5;
    localparam logic [DESER_IDX_W-1:0] LAST_IDX = 5'd31;
endpackage

// File: rtl/one_bit_decoder_32.sv
// one_bit_decoder_32: 5-to-32 one-hot decoder with enable.
// Ports: select (bit index), en (gate), onehot (one bit set when en=1, else 0).
module one_bit_decoder_32
    import bit_deserializer_32_pkg::*;
(
    input  logic [DESER_IDX_W-1:0] select,
    input  logic                   en,
    output logic [DESER_WIDTH-1:0] onehot
);
    // 2-to-4 on select[4:3] picks one of four 3-to-8 decoders,
    // matching the 8/8/8/8 split of the mux tree.
    logic [3:0] grp;
    always_comb grp = en ? (4'b0001 << select[4:3]) : 4'b0000;
    for (genvar g = 0; g < 4; g++) begin : g_dec
        assign onehot[8*g +: 8] = grp[g] ? (8'b0000_0001 << select[2:0]) : 8'b0000_0000;
    end
endmodule

// File: rtl/bit_deserializer_32.sv
// bit_deserializer_32: assembles an LSB-first serial bit stream into 32-bit words.
// Ports: clock/reset (sync, active-high); clear flushes the partial word;
// bit_in/bit_valid/bit_ready serial input handshake; word_out/out_valid/out_ready
// output register handshake; index is the next bit position to be written.
module bit_deserializer_32
    import bit_deserializer_32_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH,
    parameter int IDX_W = DESER_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] index
);
    logic [WIDTH-1:0] assembly;
    logic [WIDTH-1:0] assembly_next;
    logic [WIDTH-1:0] wr_en;
    logic             accept;
    logic             last;

    // Only the word-completing bit can stall, and only when the output is still held.
    assign bit_ready = !clear && !(index == LAST_IDX && out_valid && !out_ready);
    assign accept    = bit_valid && bit_ready;
    assign last      = accept && index == LAST_IDX;

    // Bit 31 goes straight to word_out, so the decoder only writes bits 0..30.
    one_bit_decoder_32 u_dec (
        .select (index),
        .en     (accept && !last),
        .onehot (wr_en)
    );

    always_comb assembly_next = (assembly & ~wr_en) | (wr_en & {WIDTH{bit_in}});

    always_ff @(posedge clock) begin
        if (reset) begin
            index     <= '0;
            assembly  <= '0;
            word_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (clear || last) begin
                index    <= '0;
                assembly <= '0;
            end else if (accept) begin
                index    <= index + IDX_W'(1);
                assembly <= assembly_next;
            end
            if (last) begin
                word_out  <= {bit_in, assembly[WIDTH-2:0]};
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bit_deserializer_32.sv
// tb_bit_deserializer_32: directed self-checking bench for bit_deserializer_32.
module tb_bit_deserializer_32;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic [31:0] word_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  index;

    int vectors = 0;
    int miscompares = 0;

    bit_deserializer_32 dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .word_out  (word_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .index     (index)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts and ends 1 time unit after a rising edge; returns once the bit is accepted.
    task automatic send_bit(input logic b);
        int n = 0;
        bit_in = b;
        bit_valid = 1'b1;
        #1;
        while (!bit_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("send_timeout", 32'(bit_ready), 32'd1);
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_bit(w[i]);
            if (gaps) begin
                int g = int'($urandom_range(0, 3));
                for (int k = 0; k < g; k++) tick();
                check("gap_index", 32'(index), 32'((i + 1) % 32));
            end
        end
    endtask

    initial begin
        #1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_index", 32'(index), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_word", word_out, 32'd0);
            check("idle_ready", 32'(bit_ready), 32'd1);
        end

        // Continuous stream, out_ready high
        send_bits(32'hA5A50F3C, 31, 1'b0);
        check("t2_index31", 32'(index), 32'd31);
        check("t2_valid_early", 32'(out_valid), 32'd0);
        send_bit(1'b1);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_word", word_out, 32'hA5A50F3C);
        check("t2_index0", 32'(index), 32'd0);
        tick();
        check("t2_consumed", 32'(out_valid), 32'd0);

        // Back-to-back words with downstream stall
        out_ready = 1'b0;
        send_bits(32'h00000001, 32, 1'b0);
        check("t3_word1", word_out, 32'h00000001);
        check("t3_valid1", 32'(out_valid), 32'd1);
        send_bits(32'h80000000, 31, 1'b0);
        check("t3_index31", 32'(index), 32'd31);
        bit_in = 1'b1;
        bit_valid = 1'b1;
        #1;
        check("t3_stall", 32'(bit_ready), 32'd0);
        tick();
        check("t3_hold_index", 32'(index), 32'd31);
        check("t3_hold_word", word_out, 32'h00000001);
        out_ready = 1'b1;
        #1;
        check("t3_unstall", 32'(bit_ready), 32'd1);
        tick();
        bit_valid = 1'b0;
        check("t3_passthru_valid", 32'(out_valid), 32'd1);
        check("t3_passthru_word", word_out, 32'h80000000);
        check("t3_index0", 32'(index), 32'd0);
        tick();
        check("t3_drained", 32'(out_valid), 32'd0);
        check("t3_word_held", word_out, 32'h80000000);

        // clear drops the partial word and the bit offered with it
        send_bits(32'h000003FF, 10, 1'b0);
        check("t4_index10", 32'(index), 32'd10);
        clear = 1'b1;
        bit_in = 1'b1;
        bit_valid = 1'b1;
        #1;
        check("t4_clear_ready", 32'(bit_ready), 32'd0);
        tick();
        clear = 1'b0;
        bit_valid = 1'b0;
        check("t4_index0", 32'(index), 32'd0);
        check("t4_valid_kept", 32'(out_valid), 32'd0);
        send_bits(32'h12345678, 32, 1'b0);
        check("t4_word", word_out, 32'h12345678);
        check("t4_valid", 32'(out_valid), 32'd1);
        tick();

        // Idle gaps between bits
        send_bits(32'hDEADBEEF, 32, 1'b1);
        check("t5_word", word_out, 32'hDEADBEEF);

        // Reset mid-word with a pending output
        out_ready = 1'b0;
        send_bits(32'hCAFEF00D, 32, 1'b0);
        send_bits(32'h12345678, 17, 1'b0);
        check("t6_index17", 32'(index), 32'd17);
        check("t6_pending", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_index", 32'(index), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_word", word_out, 32'd0);
        out_ready = 1'b1;
        send_bits(32'h0F0F1234, 32, 1'b0);
        check("t6_word", word_out, 32'h0F0F1234);
        check("t6_valid", 32'(out_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
